// File: rtl/fruit_pkg.sv
// ---------------------------------------------------------------------------
// fruit_pkg
// Definitions shared by the fruit sizing blocks:
//   - size class codes reported on the display/UART path
//   - state encoding of the area classifier FSM
//   - default size thresholds, also used by the colour-ratio classifier
// ---------------------------------------------------------------------------
package fruit_pkg;

   // Size class codes, ordered smallest to largest
   localparam logic [2:0] CLASS_NONE = 3'd0;
   localparam logic [2:0] CLASS_A    = 3'd1;
   localparam logic [2:0] CLASS_B    = 3'd2;
   localparam logic [2:0] CLASS_C    = 3'd3;
   localparam logic [2:0] CLASS_D    = 3'd4;

   // Area classifier FSM states
   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWait     = 3'd1,
      StAccum    = 3'd2,
      StClassify = 3'd3,
      StDebounce = 3'd4
   } state_e;

   // Default ascending area thresholds (dark-pixel counts per frame)
   localparam int unsigned AREA_T0_DEFAULT = 1000;
   localparam int unsigned AREA_T1_DEFAULT = 20000;
   localparam int unsigned AREA_T2_DEFAULT = 60000;
   localparam int unsigned AREA_T3_DEFAULT = 150000;

endpackage

// File: rtl/area_binner.sv
// ---------------------------------------------------------------------------
// area_binner
// Combinational mapping of a window-average area onto a size class using
// four ascending thresholds. An average equal to a threshold falls into the
// higher class.
// Ports:
//   avg_i    [AW-1:0]  window-average area
//   class_o  [2:0]     raw (undebounced) class code
// ---------------------------------------------------------------------------
module area_binner
   import fruit_pkg::*;
#(
   parameter int unsigned AW = 24,
   parameter int unsigned T0 = AREA_T0_DEFAULT,
   parameter int unsigned T1 = AREA_T1_DEFAULT,
   parameter int unsigned T2 = AREA_T2_DEFAULT,
   parameter int unsigned T3 = AREA_T3_DEFAULT
) (
   input  logic [AW-1:0] avg_i,
   output logic [2:0]    class_o
);

   // Compare in a common wide domain so thresholds wider than AW still work
   logic [63:0] avg_ext;

   always_comb begin
      avg_ext = 64'(avg_i);
      if (avg_ext < 64'(T0)) begin
         class_o = CLASS_NONE;
      end else if (avg_ext < 64'(T1)) begin
         class_o = CLASS_A;
      end else if (avg_ext < 64'(T2)) begin
         class_o = CLASS_B;
      end else if (avg_ext < 64'(T3)) begin
         class_o = CLASS_C;
      end else begin
         class_o = CLASS_D;
      end
   end

endmodule

// File: rtl/area_classifier.sv
// ---------------------------------------------------------------------------
// area_classifier
// Samples the per-frame dark-pixel area count on each frame sync falling
// edge, averages it over 2^AVG_LOG2 frames, bins the average into a size
// class and debounces the class over STABLE_N consecutive windows.
// Ports:
//   pixelclk    pixel clock
//   rst         synchronous reset, active-high
//   en          classification enable; low clears the window and debounce
//   i_vs        frame sync
//   i_area      area count, updated by the area stage on VS falling edge
//   o_avg_area  last completed window average
//   o_class     debounced class code
//   o_present   o_class != CLASS_NONE
//   o_valid     one-cycle pulse when o_avg_area updates
// ---------------------------------------------------------------------------
module area_classifier
   import fruit_pkg::*;
#(
   parameter int unsigned AW       = 24,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned STABLE_N = 3,
   parameter int unsigned T0       = AREA_T0_DEFAULT,
   parameter int unsigned T1       = AREA_T1_DEFAULT,
   parameter int unsigned T2       = AREA_T2_DEFAULT,
   parameter int unsigned T3       = AREA_T3_DEFAULT
) (
   input  logic          pixelclk,
   input  logic          rst,
   input  logic          en,
   input  logic          i_vs,
   input  logic [AW-1:0] i_area,
   output logic [AW-1:0] o_avg_area,
   output logic [2:0]    o_class,
   output logic          o_present,
   output logic          o_valid
);

   localparam int unsigned AccW    = AW + AVG_LOG2;
   localparam logic [3:0]  StableN = 4'(STABLE_N);

   state_e                state_q, state_d;
   logic                  vs_q;
   logic                  vs_fall;
   logic                  armed_q, armed_d;
   logic [AccW-1:0]       acc_q, acc_d;
   logic [AVG_LOG2-1:0]   frame_cnt_q, frame_cnt_d;
   logic [3:0]            stab_cnt_q, stab_cnt_d;
   logic [2:0]            cand_q, cand_d;
   logic [2:0]            raw_q, raw_d;
   logic [AW-1:0]         avg_q, avg_d;
   logic [2:0]            class_q, class_d;
   logic                  present_q, present_d;
   logic [AW-1:0]         avg_now;
   logic [2:0]            raw_now;

   // Same cycle in which the area stage latches its count
   assign vs_fall = vs_q & ~i_vs;

   // Truncating divide by the window length
   assign avg_now = acc_q[AccW-1:AVG_LOG2];

   area_binner #(
      .AW (AW),
      .T0 (T0),
      .T1 (T1),
      .T2 (T2),
      .T3 (T3)
   ) u_binner (
      .avg_i   (avg_now),
      .class_o (raw_now)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge pixelclk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            // Unarmed: the first frame edge only arms (partial frame dropped)
            StIdle:     if (vs_fall && armed_q) state_d = StWait;
            StWait:     state_d = StAccum;
            StAccum:    state_d = (&frame_cnt_q) ? StClassify : StIdle;
            StClassify: state_d = StDebounce;
            StDebounce: state_d = StIdle;
            default:    state_d = StIdle;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------------------------
   always_comb begin
      armed_d     = armed_q;
      acc_d       = acc_q;
      frame_cnt_d = frame_cnt_q;
      stab_cnt_d  = stab_cnt_q;
      cand_d      = cand_q;
      raw_d       = raw_q;
      avg_d       = avg_q;
      class_d     = class_q;
      present_d   = present_q;

      if (!en) begin
         // Outputs hold; all window and debounce history is discarded
         armed_d     = 1'b0;
         acc_d       = '0;
         frame_cnt_d = '0;
         stab_cnt_d  = '0;
         cand_d      = CLASS_NONE;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (vs_fall && !armed_q) armed_d = 1'b1;
            end
            StAccum: begin
               acc_d       = acc_q + AccW'(i_area);
               frame_cnt_d = frame_cnt_q + AVG_LOG2'(1);
            end
            StClassify: begin
               avg_d       = avg_now;
               raw_d       = raw_now;
               acc_d       = '0;
               frame_cnt_d = '0;
            end
            StDebounce: begin
               if (raw_q == cand_q) begin
                  if (stab_cnt_q < StableN) stab_cnt_d = stab_cnt_q + 4'd1;
               end else begin
                  cand_d     = raw_q;
                  stab_cnt_d = 4'd1;
               end
               // Saturated counter keeps re-confirming the same class
               if (stab_cnt_d == StableN) begin
                  class_d   = cand_d;
                  present_d = (cand_d != CLASS_NONE);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pixelclk) begin
      if (rst) begin
         vs_q        <= 1'b0;
         armed_q     <= 1'b0;
         acc_q       <= '0;
         frame_cnt_q <= '0;
         stab_cnt_q  <= '0;
         cand_q      <= CLASS_NONE;
         raw_q       <= CLASS_NONE;
         avg_q       <= '0;
         class_q     <= CLASS_NONE;
         present_q   <= 1'b0;
      end else begin
         vs_q        <= i_vs;
         armed_q     <= armed_d;
         acc_q       <= acc_d;
         frame_cnt_q <= frame_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         cand_q      <= cand_d;
         raw_q       <= raw_d;
         avg_q       <= avg_d;
         class_q     <= class_d;
         present_q   <= present_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      o_avg_area = avg_q;
      o_class    = class_q;
      o_present  = present_q;
      o_valid    = (state_q == StDebounce) && en;
   end

endmodule

// File: tb/tb_area_classifier.sv
module tb_area_classifier;

   logic        pixelclk = 1'b0;
   logic        rst;
   logic        en;
   logic        i_vs;
   logic [23:0] i_area;
   logic [23:0] o_avg_area;
   logic [2:0]  o_class;
   logic        o_present;
   logic        o_valid;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 pixelclk = ~pixelclk;

   area_classifier #(
      .AW       (24),
      .AVG_LOG2 (2),
      .STABLE_N (3)
   ) dut (
      .pixelclk   (pixelclk),
      .rst        (rst),
      .en         (en),
      .i_vs       (i_vs),
      .i_area     (i_area),
      .o_avg_area (o_avg_area),
      .o_class    (o_class),
      .o_present  (o_present),
      .o_valid    (o_valid)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge pixelclk);
      #1;
   endtask

   // One frame: VS high 3 cycles, then falls with the new area count.
   // Reports o_valid pulses and the cycle (after the VS drop) of the first.
   task automatic do_frame(input logic [23:0] area, output int nvalid, output int first_at);
      nvalid   = 0;
      first_at = -1;
      i_vs = 1'b1;
      repeat (3) tick();
      i_vs   = 1'b0;
      i_area = area;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (o_valid === 1'b1) begin
            nvalid++;
            if (first_at < 0) first_at = k;
         end
      end
   endtask

   task automatic run_window(input logic [23:0] a0, a1, a2, a3, output int nv, output int at);
      int n, f;
      nv = 0;
      do_frame(a0, n, f); nv += n;
      do_frame(a1, n, f); nv += n;
      do_frame(a2, n, f); nv += n;
      do_frame(a3, n, f); nv += n;
      at = f;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; i_vs = 1'b0; i_area = '0;
      repeat (3) tick();
      n_cmp++; if (o_avg_area !== 24'd0) begin n_fail++; $display("FAIL reset_avg: got %0d want 0", o_avg_area); end
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL reset_class: got %0d want 0", o_class); end
      n_cmp++; if (o_present !== 1'b0) begin n_fail++; $display("FAIL reset_present: got %b want 0", o_present); end
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int n, f;
      en = 1'b1;
      do_frame(24'd50000, n, f);
      n_cmp++; if (n !== 0) begin n_fail++; $display("FAIL arm_frame_valid: got %0d want 0", n); end
      run_window(24'd50000, 24'd50000, 24'd50000, 24'd50000, n, f);
      n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL win1_valid_count: got %0d want 1", n); end
      n_cmp++; if (f !== 4) begin n_fail++; $display("FAIL win1_latency: got %0d want 4", f); end
      n_cmp++; if (o_avg_area !== 24'd50000) begin n_fail++; $display("FAIL win1_avg: got %0d want 50000", o_avg_area); end
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL win1_class: got %0d want 0", o_class); end
      n_cmp++; if (o_present !== 1'b0) begin n_fail++; $display("FAIL win1_present: got %b want 0", o_present); end
      run_window(24'd50000, 24'd50000, 24'd50000, 24'd50000, n, f);
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL win2_class: got %0d want 0", o_class); end
      run_window(24'd50000, 24'd50000, 24'd50000, 24'd50000, n, f);
      n_cmp++; if (o_class !== 3'd2) begin n_fail++; $display("FAIL win3_class: got %0d want 2", o_class); end
      n_cmp++; if (o_present !== 1'b1) begin n_fail++; $display("FAIL win3_present: got %b want 1", o_present); end
   endtask

   task automatic test_thresholds();
      int n, f;
      run_window(24'd999, 24'd1001, 24'd1000, 24'd1000, n, f);
      n_cmp++; if (o_avg_area !== 24'd1000) begin n_fail++; $display("FAIL eq_avg: got %0d want 1000", o_avg_area); end
      run_window(24'd999, 24'd1001, 24'd1000, 24'd1000, n, f);
      n_cmp++; if (o_class !== 3'd2) begin n_fail++; $display("FAIL eq_class_hold: got %0d want 2", o_class); end
      run_window(24'd999, 24'd1001, 24'd1000, 24'd1000, n, f);
      n_cmp++; if (o_class !== 3'd1) begin n_fail++; $display("FAIL eq_class_a: got %0d want 1", o_class); end
      run_window(24'd0, 24'd0, 24'd0, 24'd3999, n, f);
      n_cmp++; if (o_avg_area !== 24'd999) begin n_fail++; $display("FAIL trunc_avg: got %0d want 999", o_avg_area); end
      run_window(24'd0, 24'd0, 24'd0, 24'd3999, n, f);
      run_window(24'd0, 24'd0, 24'd0, 24'd3999, n, f);
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL trunc_class: got %0d want 0", o_class); end
      n_cmp++; if (o_present !== 1'b0) begin n_fail++; $display("FAIL trunc_present: got %b want 0", o_present); end
   endtask

   task automatic test_max();
      int n, f;
      run_window(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, n, f);
      n_cmp++; if (o_avg_area !== 24'hFFFFFF) begin n_fail++; $display("FAIL max_avg: got %h want ffffff", o_avg_area); end
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL max_class_hold: got %0d want 0", o_class); end
      run_window(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, n, f);
      run_window(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, n, f);
      n_cmp++; if (o_class !== 3'd4) begin n_fail++; $display("FAIL max_class: got %0d want 4", o_class); end
      n_cmp++; if (o_present !== 1'b1) begin n_fail++; $display("FAIL max_present: got %b want 1", o_present); end
   endtask

   task automatic test_debounce_break();
      int n, f;
      logic [23:0] seq [6];
      logic [2:0]  exp_cls [6];
      seq = '{24'd200000, 24'd200000, 24'd100000, 24'd200000, 24'd200000, 24'd200000};
      exp_cls = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      for (int w = 0; w < 3; w++) run_window(24'd100000, 24'd100000, 24'd100000, 24'd100000, n, f);
      n_cmp++; if (o_class !== 3'd3) begin n_fail++; $display("FAIL est_class_c: got %0d want 3", o_class); end
      for (int w = 0; w < 6; w++) begin
         run_window(seq[w], seq[w], seq[w], seq[w], n, f);
         n_cmp++;
         if (o_class !== exp_cls[w]) begin
            n_fail++;
            $display("FAIL break_win%0d_class: got %0d want %0d", w, o_class, exp_cls[w]);
         end
      end
   endtask

   task automatic test_en_drop();
      int n, f, nv_low;
      do_frame(24'd160000, n, f);
      do_frame(24'd160000, n, f);
      en = 1'b0;
      nv_low = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (o_valid !== 1'b0) nv_low++;
      end
      n_cmp++; if (nv_low !== 0) begin n_fail++; $display("FAIL en_low_valid: got %0d pulses want 0", nv_low); end
      n_cmp++; if (o_class !== 3'd4) begin n_fail++; $display("FAIL en_low_class: got %0d want 4", o_class); end
      n_cmp++; if (o_avg_area !== 24'd200000) begin n_fail++; $display("FAIL en_low_avg: got %0d want 200000", o_avg_area); end
      en = 1'b1;
      do_frame(24'd40000, n, f);
      n_cmp++; if (n !== 0) begin n_fail++; $display("FAIL reen_arm_valid: got %0d want 0", n); end
      run_window(24'd40000, 24'd40000, 24'd40000, 24'd40000, n, f);
      n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL reen_valid_count: got %0d want 1", n); end
      n_cmp++; if (f !== 4) begin n_fail++; $display("FAIL reen_latency: got %0d want 4", f); end
      n_cmp++; if (o_avg_area !== 24'd40000) begin n_fail++; $display("FAIL reen_avg: got %0d want 40000", o_avg_area); end
      n_cmp++; if (o_class !== 3'd4) begin n_fail++; $display("FAIL reen_class_hold: got %0d want 4", o_class); end
   endtask

   task automatic test_rst_classify();
      int n, f, nv_after;
      do_frame(24'd70000, n, f);
      do_frame(24'd70000, n, f);
      do_frame(24'd70000, n, f);
      // Fourth frame by hand: VS drop, then WAIT, ACCUM, CLASSIFY
      i_vs = 1'b1;
      repeat (3) tick();
      i_vs   = 1'b0;
      i_area = 24'd70000;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cls_valid: got %b want 0", o_valid); end
      n_cmp++; if (o_avg_area !== 24'd0) begin n_fail++; $display("FAIL rst_cls_avg: got %0d want 0", o_avg_area); end
      n_cmp++; if (o_class !== 3'd0) begin n_fail++; $display("FAIL rst_cls_class: got %0d want 0", o_class); end
      n_cmp++; if (o_present !== 1'b0) begin n_fail++; $display("FAIL rst_cls_present: got %b want 0", o_present); end
      rst = 1'b0;
      nv_after = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (o_valid !== 1'b0) nv_after++;
      end
      n_cmp++; if (nv_after !== 0) begin n_fail++; $display("FAIL rst_cls_no_pulse: got %0d pulses want 0", nv_after); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_thresholds();
      test_max();
      test_debounce_break();
      test_en_drop();
      test_rst_classify();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
